// File: rtl/pio_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_spi_pkg
// Description : Shared types and constants for the PIO-driven SPI transmitter.
//               Defines the FSM state encoding, the command length codes,
//               the status-word bit positions, and helpers that decode a
//               length code.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_e;

   localparam logic [1:0] LEN8     = 2'd0;
   localparam logic [1:0] LEN16    = 2'd1;
   localparam logic [1:0] LEN24    = 2'd2;
   localparam logic [1:0] LEN_RSVD = 2'd3;

   localparam int ST_BUSY    = 0;
   localparam int ST_ACK     = 1;
   localparam int ST_ERR     = 2;
   localparam int ST_CNT_LSB = 8;

   // Number of bits carried by a length code (reserved code yields 0).
   function automatic logic [4:0] len_bits(input logic [1:0] code);
      case (code)
         LEN8:    return 5'd8;
         LEN16:   return 5'd16;
         LEN24:   return 5'd24;
         default: return 5'd0;
      endcase
   endfunction

   // Left-justify the selected payload so the first bit to send sits in [23].
   function automatic logic [23:0] align_msb(input logic [1:0] code,
                                             input logic [23:0] data);
      case (code)
         LEN8:    return {data[7:0], 16'h0000};
         LEN16:   return {data[15:0], 8'h00};
         default: return data;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pio_spi_tick.sv
`default_nettype none
// ============================================================================
// Module      : pio_spi_tick
// Description : Phase divider. Emits a one-cycle tick on the last clock of
//               every CLK_DIV-cycle interval; clear_i restarts the interval
//               so the next tick lands exactly CLK_DIV cycles later.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               clear_i  - restart interval (driven on FSM state change)
//               tick_o   - interval-complete pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pio_spi_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   output logic tick_o
);

   localparam int            CW   = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   // Driven purely from the counter register so the FSM can use it to
   // compute clear_i without forming a combinational loop.
   assign tick_o = (cnt_q == TERM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clear_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pio_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : pio_spi_tx
// Description : Interprets a 32-bit output-PIO word as an SPI transmit
//               command (toggle go bit, length code, 24 data bits) and sends
//               the payload MSB-first as an SPI mode-0 master. Reports
//               busy/ack/err/done-count through a registered status word.
// Ports       : clk       - system clock
//               reset_n   - asynchronous active-low reset
//               pio_word  - [31] go toggle, [29:28] len code, [23:0] data
//               spi_sclk  - SPI clock, idles low
//               spi_mosi  - SPI data out
//               spi_cs_n  - SPI chip select, active low
//               status    - [0] busy, [1] ack, [2] err, [15:8] done count
// Revision    : 1.0 - initial release
// ============================================================================
module pio_spi_tx
   import pio_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pio_word,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_cs_n,
   output logic [31:0] status
);

   state_e      state_q, state_d;
   logic [23:0] shift_q, shift_d;
   logic [4:0]  bits_q,  bits_d;   // bits whose falling edge is still to come
   logic        go_q,    go_d;
   logic        phase_q, phase_d;  // 0: sclk-high half, 1: sclk-low half
   logic        ack_q,   ack_d;
   logic        err_q,   err_d;
   logic        busy_q,  busy_d;
   logic [7:0]  cnt_q,   cnt_d;
   logic        sclk_q,  sclk_d;
   logic        mosi_q,  mosi_d;
   logic        cs_n_q,  cs_n_d;

   logic        w_tick;
   logic        w_clear;
   logic [1:0]  w_len;
   logic [23:0] w_aligned;
   logic        w_unused;

   assign w_len     = pio_word[29:28];
   assign w_aligned = align_msb(w_len, pio_word[23:0]);
   assign w_unused  = ^{pio_word[30], pio_word[27:24]};

   // Every state lasts a whole number of CLK_DIV intervals, so the divider
   // is restarted whenever the state changes.
   assign w_clear = (state_d != state_q);

   pio_spi_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (w_clear),
      .tick_o  (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         bits_q  <= '0;
         go_q    <= 1'b0;
         phase_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bits_q  <= bits_d;
         go_q    <= go_d;
         phase_q <= phase_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bits_d  = bits_q;
      go_d    = go_q;
      phase_d = phase_q;
      ack_d   = ack_q;
      err_d   = err_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;

      case (state_q)
         IDLE: begin
            if (pio_word[31] != ack_q) begin
               go_d = pio_word[31];
               if (w_len == LEN_RSVD) begin
                  // Reject: acknowledge so software is not left waiting.
                  ack_d = pio_word[31];
                  err_d = 1'b1;
               end else begin
                  state_d = SETUP;
                  shift_d = w_aligned;
                  bits_d  = len_bits(w_len);
                  cs_n_d  = 1'b0;
                  busy_d  = 1'b1;
                  mosi_d  = w_aligned[23];
                  err_d   = 1'b0;
               end
            end
         end

         SETUP: begin
            if (w_tick) begin
               state_d = SHIFT;
               phase_d = 1'b0;
               sclk_d  = 1'b1;
            end
         end

         SHIFT: begin
            if (w_tick) begin
               if (!phase_q) begin
                  // Falling edge: present the next bit, except after the last
                  // one, where mosi keeps the final bit through HOLD.
                  phase_d = 1'b1;
                  sclk_d  = 1'b0;
                  bits_d  = bits_q - 5'd1;
                  if (bits_q > 5'd1) begin
                     shift_d = {shift_q[22:0], 1'b0};
                     mosi_d  = shift_q[22];
                  end
               end else if (bits_q == 5'd0) begin
                  state_d = HOLD;
               end else begin
                  phase_d = 1'b0;
                  sclk_d  = 1'b1;
               end
            end
         end

         HOLD: begin
            if (w_tick) begin
               state_d = GAP;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
            end
         end

         GAP: begin
            if (w_tick) begin
               state_d = IDLE;
               ack_d   = go_q;
               busy_d  = 1'b0;
               cnt_d   = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;

   always_comb begin
      status                     = '0;
      status[ST_BUSY]            = busy_q;
      status[ST_ACK]             = ack_q;
      status[ST_ERR]             = err_q;
      status[ST_CNT_LSB +: 8]    = cnt_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_pio_spi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pio_spi_tx
// Description : Scoreboard bench for pio_spi_tx. The driver models the
//               software view (ack, err, count) and queues the expected SPI
//               frame for every command that should start a transfer; an
//               independent monitor reconstructs frames from the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_spi_tx;

   localparam int DIV = 4;

   typedef struct {
      int          n;
      logic [23:0] data;
      int          issue;   // cycle the command was presented, -1: back-to-back
      logic [31:0] st;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] pio_word = 32'h0;
   logic [31:0] pio1 = 32'h0;
   logic        sclk, mosi, cs_n, sclk1, mosi1, cs_n1;
   logic [31:0] status, status1;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   logic       ack_m = 1'b0;
   logic       err_m = 1'b0;
   logic [7:0] cnt_m = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pio_spi_tx #(.CLK_DIV(DIV)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .pio_word (pio_word),
      .spi_sclk (sclk),
      .spi_mosi (mosi),
      .spi_cs_n (cs_n),
      .status   (status)
   );

   pio_spi_tx #(.CLK_DIV(1)) u_dut_div1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .pio_word (pio1),
      .spi_sclk (sclk1),
      .spi_mosi (mosi1),
      .spi_cs_n (cs_n1),
      .status   (status1)
   );

   function automatic logic [31:0] st_word(input logic [7:0] c, input logic e,
                                           input logic a, input logic b);
      return {16'h0000, c, 5'b00000, e, a, b};
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present a command; if it should be acted on, update the software model
   // and queue (or directly verify) the expected outcome.
   task automatic issue(input logic [31:0] w);
      int          n;
      logic [23:0] d;
      @(posedge clk); #1;
      pio_word = w;
      if (w[31] != ack_m) begin
         if (w[29:28] == 2'd3) begin
            ack_m = w[31];
            err_m = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check("rsvd_status", status, st_word(cnt_m, err_m, ack_m, 1'b0));
            check("rsvd_no_cs", {30'b0, cs_n, sclk}, 32'h2);
         end else begin
            n = 8 * (int'(w[29:28]) + 1);
            d = w[23:0];
            if (n < 24) d = d & ((24'd1 << n) - 24'd1);
            ack_m = w[31];
            err_m = 1'b0;
            cnt_m = cnt_m + 8'd1;
            exp_q.push_back('{n, d, cyc, st_word(cnt_m, 1'b0, ack_m, 1'b0)});
         end
      end
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || status[0]) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout_%s: got busy after %0d cycles required idle", name, k);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: rebuild each frame from the pins and score it at completion.
   initial begin : mon
      bit          active;
      bit          gap_bad;
      bit          sclk_bad;
      int          start_c, low, nb, last_idle;
      logic [23:0] sh;
      logic        prev;
      exp_t        e;
      active = 0; last_idle = -10; start_c = 0; low = 0; nb = 0;
      sh = '0; prev = 1'b0; gap_bad = 0; sclk_bad = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            active = 0;
         end else if (!active) begin
            if (!cs_n) begin
               active = 1; start_c = cyc; low = 1; nb = 0; sh = '0;
               gap_bad = 0; sclk_bad = 0; prev = 1'b0;
               if (sclk) begin sh = {sh[22:0], mosi}; nb++; end
               prev = sclk;
            end
         end else begin
            if (!cs_n) low++;
            else begin
               if (mosi !== 1'b0) gap_bad = 1;
               if (sclk !== 1'b0) sclk_bad = 1;
            end
            if (sclk && !prev) begin sh = {sh[22:0], mosi}; nb++; end
            prev = sclk;
            if (!status[0]) begin
               active = 0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_txn: got frame of %0d bits data 0x%06h required none", nb, sh);
               end else begin
                  e = exp_q.pop_front();
                  check("nbits", 32'(nb), 32'(e.n));
                  check("data", 32'(sh), 32'(e.data));
                  check("cs_low_cycles", 32'(low), 32'(DIV * (2 + 2 * e.n)));
                  check("txn_cycles", 32'(cyc - start_c), 32'(DIV * (3 + 2 * e.n)));
                  check("status_done", status, e.st);
                  check("gap_pins", {30'b0, sclk_bad, gap_bad}, 32'h0);
                  if (e.issue < 0) check("b2b_latency", 32'(start_c - last_idle), 32'd1);
                  else             check("start_latency", 32'(start_c - e.issue), 32'd1);
               end
               last_idle = cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin : drv
      logic [31:0] w;
      logic [1:0]  lc;
      logic        g;
      int          k, r, nb, st, r1, r2;
      logic        p;
      bit          seen;
      logic [7:0]  sh8;

      repeat (3) @(negedge clk);
      check("reset_status", status, 32'h0);
      check("reset_pins", {29'b0, cs_n, sclk, mosi}, 32'h4);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Single byte, then 24-bit frames including one write that must not start.
      issue(32'h8000_00A5); wait_done("byte");
      issue(32'h8012_3456); wait_done("nostart");
      issue(32'h2012_3456); wait_done("w24a");
      issue(32'hA012_3456); wait_done("w24b");

      // Reserved length: err is sticky until the next valid start.
      issue(32'h3000_0000);
      repeat (10) @(negedge clk);
      check("err_sticky", status, st_word(cnt_m, 1'b1, ack_m, 1'b0));
      issue({~ack_m, 1'b0, 2'd1, 4'h0, 24'h00BEEF}); wait_done("err_clear");

      // Toggle go repeatedly mid-frame, ending on a mismatch.
      issue({~ack_m, 1'b0, 2'd0, 4'h0, 24'h000011});
      for (int i = 0; i < 3; i++) begin
         repeat (15) @(posedge clk); #1;
         pio_word = {1'($urandom), 1'b0, 2'($urandom_range(0, 2)), 4'h0, 24'($urandom)};
      end
      repeat (5) @(posedge clk); #1;
      lc = 2'($urandom_range(0, 2));
      w  = {~ack_m, 1'b0, lc, 4'h0, 24'($urandom)};
      pio_word = w;
      ack_m = w[31];
      cnt_m = cnt_m + 8'd1;
      exp_q.push_back('{8 * (int'(lc) + 1),
                        (lc == 2'd0) ? {16'h0, w[7:0]} : (lc == 2'd1) ? {8'h0, w[15:0]} : w[23:0],
                        -1, st_word(cnt_m, 1'b0, ack_m, 1'b0)});
      wait_done("toggle");

      // Randomized commands.
      for (int i = 0; i < 16; i++) begin
         lc = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         g  = ($urandom_range(0, 4) == 0) ? ack_m : ~ack_m;
         w  = {g, 1'($urandom), lc, 4'($urandom), 24'($urandom)};
         issue(w);
         wait_done("rand");
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Asynchronous reset during the third bit of a 16-bit frame.
      issue({~ack_m, 1'b0, 2'd1, 4'h0, 24'h00C3A5});
      r = 0; k = 0; p = 1'b0;
      while (r < 3 && k < 500) begin
         @(negedge clk);
         if (sclk && !p) r++;
         p = sclk;
         k++;
      end
      check("reach_bit3", 32'(r), 32'd3);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      ack_m = 1'b0; err_m = 1'b0; cnt_m = 8'h00;
      #1;
      check("rst_mid_pins", {29'b0, cs_n, sclk, mosi}, 32'h4);
      check("rst_mid_status", status, 32'h0);
      pio_word = 32'h1000_C3A5;
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (!cs_n || sclk || status != 32'h0) seen = 1;
      end
      check("no_txn_after_rst", {31'b0, seen}, 32'h0);

      // CLK_DIV=1 instance, 8-bit frame.
      @(posedge clk); #1;
      pio1 = 32'h8000_005A;
      @(negedge clk);
      check("div1_pre_cs", {31'b0, cs_n1}, 32'h1);
      @(negedge clk);
      check("div1_cs_low", {31'b0, cs_n1}, 32'h0);
      st = cyc; p = 1'b0; nb = 0; sh8 = 8'h00; r1 = 0; r2 = 0; k = 0;
      while (status1[0] && k < 100) begin
         if (sclk1 && !p) begin
            sh8 = {sh8[6:0], mosi1};
            nb++;
            if (nb == 1) r1 = cyc;
            if (nb == 2) r2 = cyc;
         end
         p = sclk1;
         @(negedge clk);
         k++;
      end
      check("div1_len", 32'(cyc - st), 32'd19);
      check("div1_nbits", 32'(nb), 32'd8);
      check("div1_data", {24'h0, sh8}, 32'h5A);
      check("div1_period", 32'(r2 - r1), 32'd2);
      check("div1_status", status1, 32'h0000_0102);

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
